// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one negedge-sampled feature-map RAM.
// Optional ARB_RANGE_CHECK_EN adds err pulses for addresses >= MEM_DEPTH.
module ram_access_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 11
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [NUM_REQ-1:0]        wack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         ram_address,
    output logic [DATA_W-1:0]         ram_data,
    output logic                      ram_read_signal,
    output logic                      ram_write_signal,
`ifdef ARB_RANGE_CHECK_EN
    output logic [NUM_REQ-1:0]        err,
`endif
    input  logic [DATA_W-1:0]         ram_dataout
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   lat_idx;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_data;

    logic               any_req;
    logic [IDX_W-1:0]   pick;
    logic               pick_we;
    logic [ADDR_W-1:0]  pick_addr;
    logic [DATA_W-1:0]  pick_data;
    logic               addr_oor;
    logic               addr_ok;

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        int j;
        j       = 0;
        any_req = 1'b0;
        pick    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ)
                j = j - NUM_REQ;
            if (req[IDX_W'(j)]) begin
                any_req = 1'b1;
                pick    = IDX_W'(j);
            end
        end
    end

    always_comb begin
        pick_we   = 1'b0;
        pick_addr = '0;
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                pick_we   = we[i];
                pick_addr = addr[i*ADDR_W +: ADDR_W];
                pick_data = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign addr_oor = (lat_addr >= ADDR_W'(MEM_DEPTH));

`ifdef ARB_RANGE_CHECK_EN
    assign addr_ok = !addr_oor;
`else
    logic oor_unused;
    assign oor_unused = addr_oor;
    assign addr_ok    = 1'b1;
`endif

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            lat_idx          <= '0;
            lat_we           <= 1'b0;
            lat_addr         <= '0;
            lat_data         <= '0;
            gnt              <= '0;
            rvalid           <= '0;
            wack             <= '0;
            rdata            <= '0;
            busy             <= 1'b0;
            ram_address      <= '0;
            ram_data         <= '0;
            ram_read_signal  <= 1'b0;
            ram_write_signal <= 1'b0;
`ifdef ARB_RANGE_CHECK_EN
            err              <= '0;
`endif
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            wack   <= '0;
`ifdef ARB_RANGE_CHECK_EN
            err    <= '0;
`endif
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_idx    <= pick;
                        lat_we     <= pick_we;
                        lat_addr   <= pick_addr;
                        lat_data   <= pick_data;
                        gnt[pick]  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_address      <= lat_addr;
                    ram_data         <= lat_data;
                    ram_write_signal <= addr_ok && lat_we;
                    ram_read_signal  <= addr_ok && !lat_we;
                    state            <= RESP;
                end
                RESP: begin
                    ram_write_signal <= 1'b0;
                    ram_read_signal  <= 1'b0;
                    if (!addr_ok) begin
`ifdef ARB_RANGE_CHECK_EN
                        err[lat_idx] <= 1'b1;
`endif
                    end else if (lat_we) begin
                        wack[lat_idx] <= 1'b1;
                    end else begin
                        rdata           <= ram_dataout;
                        rvalid[lat_idx] <= 1'b1;
                    end
                    if (lat_idx == IDX_W'(NUM_REQ - 1))
                        rr_ptr <= '0;
                    else
                        rr_ptr <= lat_idx + 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 11-word RAM.
// Define ARB_RANGE_CHECK_EN to also exercise the err path.
module tb_ram_access_arbiter;

    logic        clk;
    logic        RST;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [1:0]  wack;
    logic [15:0] rdata;
    logic        busy;
    logic [15:0] ram_address;
    logic [15:0] ram_data;
    logic        ram_read_signal;
    logic        ram_write_signal;
    logic [15:0] ram_dataout;
`ifdef ARB_RANGE_CHECK_EN
    logic [1:0]  err;
`endif

    int n_cmp;
    int n_bad;

    logic [15:0] mem [0:10];

    ram_access_arbiter #(
        .NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .MEM_DEPTH(11)
    ) dut (
        .clk(clk),
        .RST(RST),
        .req(req),
        .we(we),
        .addr(addr),
        .wdata(wdata),
        .gnt(gnt),
        .rvalid(rvalid),
        .wack(wack),
        .rdata(rdata),
        .busy(busy),
        .ram_address(ram_address),
        .ram_data(ram_data),
        .ram_read_signal(ram_read_signal),
        .ram_write_signal(ram_write_signal),
`ifdef ARB_RANGE_CHECK_EN
        .err(err),
`endif
        .ram_dataout(ram_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_write_signal && ram_address < 16'd11)
            mem[ram_address[3:0]] <= ram_data;
        if (ram_read_signal)
            ram_dataout <= (ram_address < 16'd11) ? mem[ram_address[3:0]] : 16'h0000;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
        req[i] = r;
        we[i]  = w;
        addr[i*16 +: 16]  = a;
        wdata[i*16 +: 16] = d;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({gnt, rvalid, wack} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_pulses: got %b want 0", {gnt, rvalid, wack});
        end
        n_cmp++;
        if (rdata !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        n_cmp++;
        if ({busy, ram_read_signal, ram_write_signal} !== 3'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 000",
                     {busy, ram_read_signal, ram_write_signal});
        end
        n_cmp++;
        if ({ram_address, ram_data} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h want 0", {ram_address, ram_data});
        end
        @(negedge clk);
        RST = 1'b1;
        tick();
        n_cmp++;
        if ({busy, gnt} !== 3'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b want 000", {busy, gnt});
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 16'd3, 16'hA5A5);
        tick();
        n_cmp++;
        if ({gnt, busy, ram_write_signal} !== 4'b0110) begin
            n_bad++;
            $display("FAIL wr_gnt: got %b want 0110", {gnt, busy, ram_write_signal});
        end
        set_req(0, 1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        n_cmp++;
        if ({gnt, busy, ram_write_signal, ram_read_signal} !== 5'b00110) begin
            n_bad++;
            $display("FAIL wr_strobe: got %b want 00110",
                     {gnt, busy, ram_write_signal, ram_read_signal});
        end
        n_cmp++;
        if ({ram_address, ram_data} !== {16'd3, 16'hA5A5}) begin
            n_bad++;
            $display("FAIL wr_bus: got %h/%h want 0003/a5a5", ram_address, ram_data);
        end
        tick();
        n_cmp++;
        if ({wack, rvalid, busy, ram_write_signal} !== 6'b010000) begin
            n_bad++;
            $display("FAIL wr_wack: got %b want 010000",
                     {wack, rvalid, busy, ram_write_signal});
        end
        tick();
        n_cmp++;
        if (wack !== 2'b00) begin
            n_bad++;
            $display("FAIL wr_wack_pulse: got %b want 00", wack);
        end
    endtask

    task automatic test_read();
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 16'd3, 16'd0);
        tick();
        n_cmp++;
        if (gnt !== 2'b10) begin
            n_bad++;
            $display("FAIL rd_gnt: got %b want 10", gnt);
        end
        set_req(1, 1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        n_cmp++;
        if ({ram_read_signal, ram_write_signal, ram_address} !== {2'b10, 16'd3}) begin
            n_bad++;
            $display("FAIL rd_strobe: got %b/%h want 10/0003",
                     {ram_read_signal, ram_write_signal}, ram_address);
        end
        tick();
        n_cmp++;
        if ({rvalid, wack, rdata} !== {2'b10, 2'b00, 16'hA5A5}) begin
            n_bad++;
            $display("FAIL rd_data: got %b/%b/%h want 10/00/a5a5", rvalid, wack, rdata);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4];
        int cnt;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 16'd1, 16'd0);
        set_req(1, 1'b1, 1'b0, 16'd2, 16'd0);
        for (int g = 0; g < 4; g++) begin
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (gnt == 2'b00 && cnt < 8);
            n_cmp++;
            if (gnt !== exp_g[g]) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got %b want %b", g, gnt, exp_g[g]);
            end
            if (g > 0) begin
                n_cmp++;
                if (cnt !== 3) begin
                    n_bad++;
                    $display("FAIL rr_spacing[%0d]: got %0d want 3 cycles", g, cnt);
                end
            end
        end
        req = '0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 16'd5, 16'h1234);
        tick();
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL mid_gnt: got %b want 01", gnt);
        end
        set_req(0, 1'b0, 1'b0, 16'd0, 16'd0);
        #2;
        RST = 1'b0;
        #1;
        n_cmp++;
        if ({busy, ram_read_signal, ram_write_signal} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_abort: got %b want 000",
                     {busy, ram_read_signal, ram_write_signal});
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({wack, ram_write_signal} !== 3'b000) begin
                n_bad++;
                $display("FAIL mid_no_wack[%0d]: got %b want 000", c, {wack, ram_write_signal});
            end
        end
        @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 16'd5, 16'd0);
        tick();
        set_req(0, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (2) tick();
        n_cmp++;
        if ({rvalid, rdata} !== {2'b01, 16'h0000}) begin
            n_bad++;
            $display("FAIL mid_readback: got %b/%h want 01/0000", rvalid, rdata);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            req = 2'($urandom_range(0, 3));
            we  = 2'($urandom_range(0, 3));
            set_req(0, req[0], we[0], 16'($urandom_range(0, 10)), 16'($urandom));
            set_req(1, req[1], we[1], 16'($urandom_range(0, 10)), 16'($urandom));
            tick();
            n_cmp++;
            if ((ram_read_signal && ram_write_signal) || !$onehot0(gnt) ||
                !$onehot0(rvalid) || !$onehot0(wack)) begin
                n_bad++;
                $display("FAIL excl[%0d]: got rd%b wr%b gnt%b rv%b wa%b want exclusive",
                         c, ram_read_signal, ram_write_signal, gnt, rvalid, wack);
            end
        end
        @(negedge clk);
        req = '0;
        repeat (3) tick();
    endtask

`ifdef ARB_RANGE_CHECK_EN
    task automatic test_range();
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 16'd11, 16'd0);
        set_req(1, 1'b1, 1'b0, 16'd2, 16'd0);
        tick();
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL oor_gnt: got %b want 01", gnt);
        end
        set_req(0, 1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        n_cmp++;
        if ({ram_read_signal, ram_write_signal} !== 2'b00) begin
            n_bad++;
            $display("FAIL oor_strobe: got %b want 00", {ram_read_signal, ram_write_signal});
        end
        tick();
        n_cmp++;
        if ({err, rvalid, rdata} !== {2'b01, 2'b00, 16'h0000}) begin
            n_bad++;
            $display("FAIL oor_err: got %b/%b/%h want 01/00/0000", err, rvalid, rdata);
        end
        tick();
        n_cmp++;
        if (gnt !== 2'b10) begin
            n_bad++;
            $display("FAIL oor_next_gnt: got %b want 10", gnt);
        end
        req = '0;
        repeat (2) tick();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ram_dataout = '0;
        for (int i = 0; i < 11; i++)
            mem[i] = '0;
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_reset_mid();
        test_random();
`ifdef ARB_RANGE_CHECK_EN
        test_range();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
